iob_iob2wb_bridge: RTL and testbench

IOB_IOB2WB_BRIDGE -- requirements
Module: iob_iob2wb_bridge

---
 rtl/iob_iob2wb_bridge.sv | 158 +++++++++++++++
 tb/tb_iob_iob2wb_bridge.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/iob_iob2wb_bridge.sv
// IOb-to-Wishbone bridge: queues IOb requests in a small FIFO and replays them as single Wishbone cycles.
// Define IOB_IOB2WB_TIMEOUT_EN to terminate stalled Wishbone cycles after 2**TIMEOUT_W-1 cycles.
module iob_iob2wb_bridge #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int REQ_DEPTH = 4,
    parameter int TIMEOUT_W = 8
) (
    input  logic                         clk_i,
    input  logic                         arst_i,
    input  logic                         valid_i,
    input  logic [ADDR_W-1:0]            addr_i,
    input  logic [DATA_W-1:0]            wdata_i,
    input  logic [DATA_W/8-1:0]          wstrb_i,
    output logic                         ready_o,
    output logic                         rvalid_o,
    output logic [DATA_W-1:0]            rdata_o,
    output logic [ADDR_W-1:0]            wb_adr_o,
    output logic [DATA_W/8-1:0]          wb_sel_o,
    output logic                         wb_we_o,
    output logic                         wb_cyc_o,
    output logic                         wb_stb_o,
    output logic [DATA_W-1:0]            wb_dat_o,
    input  logic                         wb_ack_i,
    input  logic                         wb_err_i,
    input  logic [DATA_W-1:0]            wb_dat_i,
    output logic                         err_o,
    input  logic                         err_clr_i,
    output logic [$clog2(REQ_DEPTH):0]   pending_o
);

    localparam int STRB_W = DATA_W / 8;
    localparam int PTR_W  = $clog2(REQ_DEPTH);
    localparam int CNT_W  = PTR_W + 1;

    typedef enum logic {
        IDLE = 1'b0,
        BUS  = 1'b1
    } state_t;

    state_t state, state_nxt;

    logic [ADDR_W-1:0] adr_mem [REQ_DEPTH];
    logic [DATA_W-1:0] dat_mem [REQ_DEPTH];
    logic [STRB_W-1:0] sel_mem [REQ_DEPTH];

    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic              full;
    logic              empty;
    logic              push;
    logic              pop;
    logic              load;
    logic              bus_fail;
    logic              tmo_hit;

    assign full      = (count == CNT_W'(REQ_DEPTH));
    assign empty     = (count == '0);
    assign push      = valid_i && !full;
    assign ready_o   = !full;
    assign pending_o = count;
    assign wb_cyc_o  = (state == BUS);
    assign wb_stb_o  = (state == BUS);

    // Payload storage carries no reset; only pointers and count define validity.
    always_ff @(posedge clk_i) begin
        if (push) begin
            adr_mem[wr_ptr] <= addr_i;
            dat_mem[wr_ptr] <= wdata_i;
            sel_mem[wr_ptr] <= wstrb_i;
        end
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        pop       = 1'b0;
        bus_fail  = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    state_nxt = BUS;
                    load      = 1'b1;
                end
            end
            BUS: begin
                if (wb_ack_i || wb_err_i || tmo_hit) begin
                    state_nxt = IDLE;
                    pop       = 1'b1;
                    bus_fail  = wb_err_i || tmo_hit;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Bus signals are latched from the FIFO head on entry to BUS so they stay stable for the cycle.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            wb_adr_o <= '0;
            wb_dat_o <= '0;
            wb_sel_o <= '0;
            wb_we_o  <= 1'b0;
        end else if (load) begin
            wb_adr_o <= adr_mem[rd_ptr];
            wb_dat_o <= dat_mem[rd_ptr];
            wb_we_o  <= |sel_mem[rd_ptr];
            wb_sel_o <= (|sel_mem[rd_ptr]) ? sel_mem[rd_ptr] : {STRB_W{1'b1}};
        end
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            rvalid_o <= 1'b0;
            rdata_o  <= '0;
            err_o    <= 1'b0;
        end else begin
            rvalid_o <= pop && !wb_we_o;
            if (pop && !wb_we_o) rdata_o <= bus_fail ? '0 : wb_dat_i;
            // A new error wins over a same-cycle clear.
            if (pop && bus_fail) err_o <= 1'b1;
            else if (err_clr_i)  err_o <= 1'b0;
        end
    end

`ifdef IOB_IOB2WB_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] tmo_cnt;

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i)                  tmo_cnt <= '0;
        else if (state == BUS && !pop) tmo_cnt <= tmo_cnt + TIMEOUT_W'(1);
        else                         tmo_cnt <= '0;
    end

    assign tmo_hit = (state == BUS) && (tmo_cnt == {TIMEOUT_W{1'b1}});
`else
    assign tmo_hit = 1'b0;
`endif

endmodule

// File: tb/tb_iob_iob2wb_bridge.sv
// Directed bench for iob_iob2wb_bridge with a simple Wishbone slave model driven on the falling edge.
module tb_iob_iob2wb_bridge;

    logic        clk = 1'b0;
    logic        arst_i = 1'b0;
    logic        valid_i = 1'b0;
    logic [31:0] addr_i = '0;
    logic [31:0] wdata_i = '0;
    logic [3:0]  wstrb_i = '0;
    logic        ready_o, rvalid_o;
    logic [31:0] rdata_o;
    logic [31:0] wb_adr_o, wb_dat_o;
    logic [3:0]  wb_sel_o;
    logic        wb_we_o, wb_cyc_o, wb_stb_o;
    logic        wb_ack_i = 1'b0;
    logic        wb_err_i = 1'b0;
    logic [31:0] wb_dat_i = '0;
    logic        err_o;
    logic        err_clr_i = 1'b0;
    logic [2:0]  pending_o;

    iob_iob2wb_bridge #(
        .ADDR_W(32), .DATA_W(32), .REQ_DEPTH(4), .TIMEOUT_W(4)
    ) dut (
        .clk_i(clk), .arst_i(arst_i),
        .valid_i(valid_i), .addr_i(addr_i), .wdata_i(wdata_i), .wstrb_i(wstrb_i),
        .ready_o(ready_o), .rvalid_o(rvalid_o), .rdata_o(rdata_o),
        .wb_adr_o(wb_adr_o), .wb_sel_o(wb_sel_o), .wb_we_o(wb_we_o),
        .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_dat_o(wb_dat_o),
        .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i), .wb_dat_i(wb_dat_i),
        .err_o(err_o), .err_clr_i(err_clr_i), .pending_o(pending_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // slv_mode: 0 stall, 1 ack, 2 err, 3 ack+err
    int  slv_mode = 1;
    int  slv_wait = 0;
    bit  force_ack = 0, force_err = 0, tb_clr = 0, clr_on_err = 0;
    int  cyc_n = 0, ack_cyc = 0, rv_cyc = 0, bus_cnt = 0, last_len = 0;
    logic [31:0] log_adr[$];
    logic [31:0] log_dat[$];
    logic        log_we[$];
    logic [3:0]  log_sel[$];
    logic [31:0] rv_q[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Slave model and response monitor; slave data is address + 0x1000_0000.
    always @(negedge clk) begin
        logic s_ack, s_err;
        cyc_n++;
        s_ack = 1'b0;
        s_err = 1'b0;
        if (wb_cyc_o && wb_stb_o) begin
            if (slv_mode != 0 && bus_cnt >= slv_wait) begin
                s_ack = (slv_mode == 1) || (slv_mode == 3);
                s_err = (slv_mode >= 2);
                log_adr.push_back(wb_adr_o);
                log_dat.push_back(wb_dat_o);
                log_we.push_back(wb_we_o);
                log_sel.push_back(wb_sel_o);
                ack_cyc = cyc_n;
            end
            bus_cnt++;
        end else begin
            if (bus_cnt != 0) last_len = bus_cnt;
            bus_cnt = 0;
        end
        wb_ack_i  = s_ack | force_ack;
        wb_err_i  = s_err | force_err;
        err_clr_i = tb_clr | (clr_on_err & s_err);
        wb_dat_i  = wb_adr_o + 32'h1000_0000;
        if (rvalid_o) begin
            rv_q.push_back(rdata_o);
            rv_cyc = cyc_n;
        end
    end

    task automatic clear_logs();
        log_adr.delete(); log_dat.delete(); log_we.delete(); log_sel.delete(); rv_q.delete();
    endtask

    task automatic send(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        bit ok;
        ok = 0;
        valid_i = 1'b1; addr_i = a; wdata_i = d; wstrb_i = s;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (ready_o) begin
                ok = 1;
                break;
            end
        end
        if (!ok) check("send_timeout", 0, 1);
        @(posedge clk); #1;
        valid_i = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (pending_o == 0 && !wb_cyc_o && !rvalid_o) begin
                ok = 1;
                break;
            end
        end
        if (!ok) check("idle_timeout", 0, 1);
        @(posedge clk); #1;
    endtask

    task automatic clr_pulse();
        tb_clr = 1;
        @(posedge clk); #1;
        tb_clr = 0;
        @(posedge clk); #1;
    endtask

    logic [31:0] exp_adr [6] = '{32'h100, 32'h104, 32'h108, 32'h10C, 32'h110, 32'h114};
    logic        exp_we  [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [3:0]  exp_sel [6] = '{4'hF, 4'h3, 4'hF, 4'hF, 4'hC, 4'hF};
    logic [3:0]  req_strb[6] = '{4'h0, 4'h3, 4'h0, 4'h0, 4'hC, 4'h0};
    logic [31:0] exp_rd  [4] = '{32'h1000_0100, 32'h1000_0108, 32'h1000_010C, 32'h1000_0114};

    initial begin
        #1 arst_i = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        check("rst_ready", ready_o, 1);
        check("rst_rvalid", rvalid_o, 0);
        check("rst_rdata", rdata_o, 0);
        check("rst_cyc", wb_cyc_o, 0);
        check("rst_stb", wb_stb_o, 0);
        check("rst_we", wb_we_o, 0);
        check("rst_adr", wb_adr_o, 0);
        check("rst_dat", wb_dat_o, 0);
        check("rst_sel", wb_sel_o, 0);
        check("rst_err", err_o, 0);
        check("rst_pending", pending_o, 0);
        arst_i = 1'b0;
        @(posedge clk); #1;

        // Posted write, immediate ack
        clear_logs();
        slv_mode = 1; slv_wait = 0;
        send(32'h10, 32'hDEAD_BEEF, 4'hF);
        wait_idle();
        check("wr_log_n", log_adr.size(), 1);
        check("wr_adr", log_adr[0], 32'h10);
        check("wr_dat", log_dat[0], 32'hDEAD_BEEF);
        check("wr_we", log_we[0], 1);
        check("wr_sel", log_sel[0], 4'hF);
        check("wr_no_rvalid", rv_q.size(), 0);

        // Read with 3 wait states
        clear_logs();
        slv_wait = 3;
        send(32'h20, 32'h0, 4'h0);
        wait_idle();
        check("rd_log_n", log_adr.size(), 1);
        check("rd_adr", log_adr[0], 32'h20);
        check("rd_we", log_we[0], 0);
        check("rd_sel", log_sel[0], 4'hF);
        check("rd_bus_len", last_len, 4);
        check("rd_rv_n", rv_q.size(), 1);
        check("rd_data", rv_q[0], 32'h1000_0020);
        check("rd_rv_lat", rv_cyc - ack_cyc, 1);
        check("rd_hold", rdata_o, 32'h1000_0020);

        // Stalled slave, six back-to-back requests
        clear_logs();
        slv_mode = 0; slv_wait = 0;
        for (int i = 0; i < 4; i++) send(exp_adr[i], 32'hA0 + i, req_strb[i]);
        @(negedge clk);
        check("full_ready", ready_o, 0);
        check("full_pending", pending_o, 4);
        @(posedge clk); #1;
        slv_mode = 1;
        for (int i = 4; i < 6; i++) send(exp_adr[i], 32'hA0 + i, req_strb[i]);
        wait_idle();
        check("burst_log_n", log_adr.size(), 6);
        for (int i = 0; i < 6; i++) begin
            check($sformatf("burst_adr%0d", i), log_adr[i], exp_adr[i]);
            check($sformatf("burst_we%0d", i), log_we[i], exp_we[i]);
            check($sformatf("burst_sel%0d", i), log_sel[i], exp_sel[i]);
        end
        check("burst_rv_n", rv_q.size(), 4);
        for (int i = 0; i < 4; i++) check($sformatf("burst_rd%0d", i), rv_q[i], exp_rd[i]);

        // Error termination, clear, and clear colliding with a new error
        clear_logs();
        slv_mode = 2; slv_wait = 0;
        send(32'h24, 32'h0, 4'h0);
        wait_idle();
        check("err_rv_n", rv_q.size(), 1);
        check("err_rdata", rv_q[0], 0);
        check("err_set", err_o, 1);
        clr_pulse();
        check("err_clr", err_o, 0);
        clear_logs();
        slv_mode = 3; slv_wait = 1; clr_on_err = 1;
        send(32'h30, 32'h0, 4'h0);
        wait_idle();
        clr_on_err = 0;
        check("ackerr_rv_n", rv_q.size(), 1);
        check("ackerr_rdata", rv_q[0], 0);
        check("setclr_err", err_o, 1);
        clr_pulse();

        // Strobes outside BUS must be ignored
        clear_logs();
        force_ack = 1; force_err = 1;
        repeat (3) @(posedge clk);
        #1 force_ack = 0; force_err = 0;
        repeat (2) @(posedge clk);
        #1;
        check("idle_ack_err", err_o, 0);
        check("idle_ack_rv", rv_q.size(), 0);
        check("idle_ack_pend", pending_o, 0);

`ifdef IOB_IOB2WB_TIMEOUT_EN
        clear_logs();
        slv_mode = 0;
        send(32'h40, 32'h0, 4'h0);
        wait_idle();
        check("tmo_bus_len", last_len, 16);
        check("tmo_rv_n", rv_q.size(), 1);
        check("tmo_rdata", rv_q[0], 0);
        check("tmo_err", err_o, 1);
        clr_pulse();
`endif

        // Reset in the middle of a stalled transfer
        clear_logs();
        slv_mode = 0;
        for (int i = 0; i < 3; i++) send(32'h200 + 4 * i, 32'h0, 4'h0);
        check("pre_rst_pend", pending_o, 3);
        check("pre_rst_cyc", wb_cyc_o, 1);
        #2 arst_i = 1'b1;
        #1;
        check("mid_rst_cyc", wb_cyc_o, 0);
        check("mid_rst_pend", pending_o, 0);
        check("mid_rst_ready", ready_o, 1);
        @(posedge clk); #1;
        arst_i = 1'b0;
        slv_mode = 1;
        repeat (10) @(posedge clk);
        #1;
        check("post_rst_rv", rv_q.size(), 0);
        check("post_rst_bus", log_adr.size(), 0);
        check("post_rst_pend", pending_o, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
